lsu_access_ctrl: RTL and testbench

Sequencer between the pipeline memory stage and `lsu`. It accepts one byte, halfword or word request per handshake and always issues word-aligned accesses to the LSU, with a byte-lane mask. An access that crosses a word boundary is split into two consecutive LSU accesses. For loads, the block merges the two raw words, then extracts and sign- or zero-extends the result.

---
 rtl/lsu_access_ctrl.sv | 159 +++++++++++++++
 tb/tb_lsu_access_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_access_ctrl.sv
// Word-aligned LSU access sequencer: lane masks, store shifting, split
// accesses across word boundaries and load merge/extension.
module lsu_access_ctrl #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic        i_req_wren,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_signed,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_rsp_split,
    output logic [31:0] o_lsu_addr,
    output logic [31:0] o_lsu_st_data,
    output logic        o_lsu_wren,
    output logic [3:0]  o_lsu_load_type,
    output logic        o_lsu_load_signed,
    input  logic [31:0] i_lsu_ld_data
);
    typedef enum logic [1:0] {IDLE, ACC1, ACC2} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_addr0, r_data0, r_data1, r_w0, r_rsp_rdata;
    logic [3:0]  r_mask0, r_mask1;
    logic [1:0]  r_k, r_size;
    logic        r_signed, r_wren, r_split;
    logic        r_rsp_valid, r_rsp_err, r_rsp_split;

    logic [7:0]  w_pat, w_lanes;
    logic [5:0]  w_sh_in, w_sh;
    logic [31:0] w_lo, w_hi, w_merged, w_ext;
    logic        w_accept, w_cross, w_reject, w_done;

    always_comb begin
        case (i_req_size)
            2'd0:    w_pat = 8'h01;
            2'd1:    w_pat = 8'h03;
            default: w_pat = 8'h0F;
        endcase
    end

    // Low nibble is the first word's lanes, high nibble spills into the next
    assign w_lanes  = w_pat << i_req_addr[1:0];
    assign w_cross  = |w_lanes[7:4];
    assign w_accept = i_req_valid && (r_state == IDLE);
    assign w_reject = w_accept && w_cross && !ALLOW_MISALIGNED;
    assign w_sh_in  = {1'b0, i_req_addr[1:0], 3'b000};
    assign w_sh     = {1'b0, r_k, 3'b000};
    assign w_done   = (r_state == ACC1 && !r_split) || (r_state == ACC2);

    assign w_lo     = (r_state == ACC2) ? r_w0 : i_lsu_ld_data;
    assign w_hi     = (r_state == ACC2) ? i_lsu_ld_data : 32'h0;
    assign w_merged = (w_lo >> w_sh) | (w_hi << (6'd32 - w_sh));

    always_comb begin
        case (r_size)
            2'd0:    w_ext = {{24{r_signed & w_merged[7]}}, w_merged[7:0]};
            2'd1:    w_ext = {{16{r_signed & w_merged[15]}}, w_merged[15:0]};
            default: w_ext = w_merged;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept && !w_reject) w_next = ACC1;
            ACC1:    w_next = r_split ? ACC2 : IDLE;
            ACC2:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_addr0     <= 32'h0;
            r_data0     <= 32'h0;
            r_data1     <= 32'h0;
            r_w0        <= 32'h0;
            r_mask0     <= 4'h0;
            r_mask1     <= 4'h0;
            r_k         <= 2'd0;
            r_size      <= 2'd0;
            r_signed    <= 1'b0;
            r_wren      <= 1'b0;
            r_split     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_rsp_split <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_rsp_split <= 1'b0;
            if (w_accept) begin
                r_addr0  <= {i_req_addr[31:2], 2'b00};
                r_k      <= i_req_addr[1:0];
                r_size   <= i_req_size;
                r_signed <= i_req_signed;
                r_wren   <= i_req_wren;
                r_split  <= w_cross;
                r_mask0  <= w_lanes[3:0];
                r_mask1  <= w_lanes[7:4];
                r_data0  <= i_req_wdata << w_sh_in;
                r_data1  <= i_req_wdata >> (6'd32 - w_sh_in);
            end
            if (w_reject) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b1;
            end
            if (r_state == ACC1) r_w0 <= i_lsu_ld_data;
            if (w_done) begin
                r_rsp_valid <= 1'b1;
                r_rsp_split <= r_split;
                r_rsp_rdata <= r_wren ? 32'h0 : w_ext;
            end
        end
    end

    always_comb begin
        o_lsu_addr    = 32'h0;
        o_lsu_st_data = 32'h0;
        o_lsu_wren    = 1'b0;
        o_lsu_load_type = 4'h0;
        case (r_state)
            ACC1: begin
                o_lsu_addr      = r_addr0;
                o_lsu_st_data   = r_data0;
                o_lsu_wren      = r_wren;
                o_lsu_load_type = r_mask0;
            end
            ACC2: begin
                o_lsu_addr      = r_addr0 + 32'd4;
                o_lsu_st_data   = r_data1;
                o_lsu_wren      = r_wren;
                o_lsu_load_type = r_mask1;
            end
            default: ;
        endcase
    end

    assign o_req_ready       = (r_state == IDLE);
    assign o_lsu_load_signed = 1'b0;
    assign o_rsp_valid       = r_rsp_valid;
    assign o_rsp_rdata       = r_rsp_rdata;
    assign o_rsp_err         = r_rsp_err;
    assign o_rsp_split       = r_rsp_split;
endmodule

// File: tb/tb_lsu_access_ctrl.sv
// Bench for lsu_access_ctrl: fixed vectors, byte-memory reference model,
// reset abort and the reject-misaligned variant.
module tb_lsu_access_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_init = 1'b1;
    always #5 clk = ~clk;

    logic        valid, wren, sgn;
    logic [31:0] addr, wdata;
    logic [1:0]  size;
    logic        ready, rsp_valid, rsp_err, rsp_split, lsu_wren, lsu_sgn;
    logic [31:0] rsp_rdata, lsu_addr, lsu_st, lsu_ld;
    logic [3:0]  lsu_type;

    logic        e_valid, e_wren, e_sgn;
    logic [31:0] e_addr, e_wdata;
    logic [1:0]  e_size;
    logic        e_ready, e_rsp_valid, e_rsp_err, e_rsp_split;
    logic        e_lsu_wren, e_lsu_sgn;
    logic [31:0] e_rsp_rdata, e_lsu_addr, e_lsu_st;
    logic [31:0] e_lsu_ld;
    logic [3:0]  e_lsu_type;

    lsu_access_ctrl #(.ALLOW_MISALIGNED(1'b1)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_req_valid(valid), .o_req_ready(ready),
        .i_req_addr(addr), .i_req_wdata(wdata),
        .i_req_wren(wren), .i_req_size(size), .i_req_signed(sgn),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata),
        .o_rsp_err(rsp_err), .o_rsp_split(rsp_split),
        .o_lsu_addr(lsu_addr), .o_lsu_st_data(lsu_st),
        .o_lsu_wren(lsu_wren), .o_lsu_load_type(lsu_type),
        .o_lsu_load_signed(lsu_sgn), .i_lsu_ld_data(lsu_ld)
    );

    lsu_access_ctrl #(.ALLOW_MISALIGNED(1'b0)) dut_rej (
        .i_clk(clk), .i_reset(rst),
        .i_req_valid(e_valid), .o_req_ready(e_ready),
        .i_req_addr(e_addr), .i_req_wdata(e_wdata),
        .i_req_wren(e_wren), .i_req_size(e_size), .i_req_signed(e_sgn),
        .o_rsp_valid(e_rsp_valid), .o_rsp_rdata(e_rsp_rdata),
        .o_rsp_err(e_rsp_err), .o_rsp_split(e_rsp_split),
        .o_lsu_addr(e_lsu_addr), .o_lsu_st_data(e_lsu_st),
        .o_lsu_wren(e_lsu_wren), .o_lsu_load_type(e_lsu_type),
        .o_lsu_load_signed(e_lsu_sgn), .i_lsu_ld_data(e_lsu_ld)
    );

    assign e_lsu_ld = 32'h8765_4321;

    // LSU memory seen by the main instance (256 bytes, address aliased)
    logic [7:0] mem [0:255];
    logic [7:0] ref_mem [0:255];
    wire  [7:0] la = lsu_addr[7:0];
    assign lsu_ld = {mem[la + 8'd3], mem[la + 8'd2], mem[la + 8'd1], mem[la]};

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 5);
        end else if (lsu_wren) begin
            for (int i = 0; i < 4; i++)
                if (lsu_type[i]) mem[la + 8'(i)] <= lsu_st[8*i +: 8];
        end
    end

    int          ncyc, nwr;
    logic [31:0] ma0, ma1, md0, md1;
    logic [3:0]  mm0, mm1;
    bit          bad_align, cur;

    always @(negedge clk) begin
        logic [3:0]  t;
        logic [31:0] a, d;
        logic        w;
        t = cur ? e_lsu_type : lsu_type;
        a = cur ? e_lsu_addr : lsu_addr;
        d = cur ? e_lsu_st : lsu_st;
        w = cur ? e_lsu_wren : lsu_wren;
        if (t != 4'h0 || w) begin
            if (ncyc == 0) begin ma0 = a; mm0 = t; md0 = d; end
            else begin ma1 = a; mm1 = t; md1 = d; end
            ncyc++;
            if (w) nwr++;
            if (a[1:0] != 2'b00) bad_align = 1'b1;
        end
    end

    int pass = 0;
    int total = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h want %h", nm, act, exp);
        else pass++;
    endtask

    function automatic int nb(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a,
                                               input logic [1:0] sz,
                                               input bit s);
        logic [31:0] v;
        int n;
        n = nb(sz);
        v = 32'h0;
        for (int i = 0; i < n; i++)
            v |= 32'(ref_mem[8'(a + 32'(i))]) << (8 * i);
        if (n < 4 && s && v[8*n-1]) v |= ~((32'h1 << (8 * n)) - 32'h1);
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] wd,
                               input logic [1:0] sz);
        for (int i = 0; i < nb(sz); i++)
            ref_mem[8'(a + 32'(i))] = wd[8*i +: 8];
    endtask

    task automatic run(input bit sel, input logic [31:0] a, wd,
                       input bit w, input logic [1:0] sz, input bit s,
                       output logic [31:0] rd, output bit er, sp,
                       output int lat, output bit got, rdy, idle0, stuck);
        @(negedge clk);
        ncyc = 0; nwr = 0; bad_align = 1'b0; cur = sel;
        ma0 = 0; ma1 = 0; md0 = 0; md1 = 0; mm0 = 0; mm1 = 0;
        if (sel) begin
            e_valid = 1; e_addr = a; e_wdata = wd;
            e_wren = w; e_size = sz; e_sgn = s;
        end else begin
            valid = 1; addr = a; wdata = wd;
            wren = w; size = sz; sgn = s;
        end
        @(posedge clk); #1;
        valid = 0; e_valid = 0;
        addr = $urandom; wdata = $urandom; wren = 1'($urandom);
        size = 2'($urandom); sgn = 1'($urandom);
        e_addr = $urandom; e_wdata = $urandom;
        lat = 1; got = 0; rd = 0; er = 0; sp = 0;
        rdy = 0; idle0 = 0; stuck = 0;
        while (!got && lat < 10) begin
            if (sel ? e_rsp_valid : rsp_valid) begin
                got = 1;
                rd  = sel ? e_rsp_rdata : rsp_rdata;
                er  = sel ? e_rsp_err : rsp_err;
                sp  = sel ? e_rsp_split : rsp_split;
                rdy = sel ? e_ready : ready;
                idle0 = sel ?
                    (e_lsu_type == 0 && !e_lsu_wren && e_lsu_addr == 0 &&
                     e_lsu_st == 0 && !e_lsu_sgn) :
                    (lsu_type == 0 && !lsu_wren && lsu_addr == 0 &&
                     lsu_st == 0 && !lsu_sgn);
            end else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        if (got) begin
            @(posedge clk); #1;
            stuck = sel ? e_rsp_valid : rsp_valid;
        end
    endtask

    task automatic chkreq(input string tg, input bit sel,
                          input logic [31:0] a, wd, input bit w,
                          input logic [1:0] sz, input bit s,
                          input logic [31:0] erd, input bit esp, eer,
                          input int elat, encyc);
        logic [31:0] rd;
        bit er, sp, got, rdy, idle0, stuck;
        int lat;
        run(sel, a, wd, w, sz, s, rd, er, sp, lat, got, rdy, idle0, stuck);
        chk({tg, " rsp"}, 32'(got), 32'd1);
        chk({tg, " rdata"}, rd, erd);
        chk({tg, " split"}, 32'(sp), 32'(esp));
        chk({tg, " err"}, 32'(er), 32'(eer));
        chk({tg, " latency"}, 32'(lat), 32'(elat));
        chk({tg, " lsu_cycles"}, 32'(ncyc), 32'(encyc));
        chk({tg, " wr_cycles"}, 32'(nwr), w ? 32'(encyc) : 32'd0);
        chk({tg, " align"}, 32'(bad_align), 32'd0);
        chk({tg, " ready_at_rsp"}, 32'(rdy), 32'd1);
        chk({tg, " lsu_idle"}, 32'(idle0), 32'd1);
        chk({tg, " pulse"}, 32'(stuck), 32'd0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wren;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] rdata;
        logic        split;
        int          lat;
        int          ncyc;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [3:0]  m0;
        logic [3:0]  m1;
        logic [31:0] d0;
        logic [31:0] d1;
    } vec_t;

    vec_t vt [10];

    initial begin
        logic [31:0] a, wd, erd;
        logic [1:0]  sz;
        bit          w, s, esp, seen;
        int          n;

        valid = 0; addr = 0; wdata = 0; wren = 0; size = 0; sgn = 0;
        e_valid = 0; e_addr = 0; e_wdata = 0; e_wren = 0; e_size = 0;
        e_sgn = 0; cur = 0; ncyc = 0; nwr = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 5);

        vt[0] = '{32'h10, 32'hDEADBEEF, 1, 2'd2, 0, 32'h0, 0, 2, 1,
                  32'h10, 32'h0, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0};
        vt[1] = '{32'h10, 32'h0, 0, 2'd2, 0, 32'hDEADBEEF, 0, 2, 1,
                  32'h10, 32'h0, 4'hF, 4'h0, 32'h0, 32'h0};
        vt[2] = '{32'h12, 32'hAABBCCDD, 1, 2'd2, 0, 32'h0, 1, 3, 2,
                  32'h10, 32'h14, 4'hC, 4'h3, 32'hCCDD0000, 32'h0000AABB};
        vt[3] = '{32'h12, 32'h0, 0, 2'd2, 0, 32'hAABBCCDD, 1, 3, 2,
                  32'h10, 32'h14, 4'hC, 4'h3, 32'h0, 32'h0};
        vt[4] = '{32'h13, 32'h0, 0, 2'd1, 1, 32'hFFFFBBCC, 1, 3, 2,
                  32'h10, 32'h14, 4'h8, 4'h1, 32'h0, 32'h0};
        vt[5] = '{32'h11, 32'h0, 0, 2'd0, 0, 32'h000000BE, 0, 2, 1,
                  32'h10, 32'h0, 4'h2, 4'h0, 32'h0, 32'h0};
        vt[6] = '{32'h10, 32'h0, 0, 2'd0, 1, 32'hFFFFFFEF, 0, 2, 1,
                  32'h10, 32'h0, 4'h1, 4'h0, 32'h0, 32'h0};
        vt[7] = '{32'hFFFFFFFE, 32'h11223344, 1, 2'd2, 0, 32'h0, 1, 3, 2,
                  32'hFFFFFFFC, 32'h0, 4'hC, 4'h3, 32'h33440000, 32'h00001122};
        vt[8] = '{32'hFFFFFFFE, 32'h0, 0, 2'd3, 0, 32'h11223344, 1, 3, 2,
                  32'hFFFFFFFC, 32'h0, 4'hC, 4'h3, 32'h0, 32'h0};
        vt[9] = '{32'hFFFFFFFF, 32'h0, 0, 2'd1, 0, 32'h00002233, 1, 3, 2,
                  32'hFFFFFFFC, 32'h0, 4'h8, 4'h1, 32'h0, 32'h0};

        repeat (2) @(negedge clk);
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset rsp", {rsp_valid, rsp_err, rsp_split, rsp_rdata[28:0]},
            32'h0);
        chk("reset lsu_addr", lsu_addr, 32'h0);
        chk("reset lsu_st", lsu_st, 32'h0);
        chk("reset lsu_ctl", {26'h0, lsu_wren, lsu_sgn, lsu_type}, 32'h0);
        mem_init = 0;
        rst = 0;

        for (int i = 0; i < 10; i++) begin
            string tg;
            tg = $sformatf("tbl%0d", i);
            chkreq(tg, 0, vt[i].addr, vt[i].wdata, vt[i].wren, vt[i].size,
                   vt[i].sgn, vt[i].rdata, vt[i].split, 0, vt[i].lat,
                   vt[i].ncyc);
            chk({tg, " a0"}, ma0, vt[i].a0);
            chk({tg, " a1"}, ma1, vt[i].a1);
            chk({tg, " m0"}, 32'(mm0), 32'(vt[i].m0));
            chk({tg, " m1"}, 32'(mm1), 32'(vt[i].m1));
            chk({tg, " d0"}, md0, vt[i].d0);
            chk({tg, " d1"}, md1, vt[i].d1);
            if (vt[i].wren) model_store(vt[i].addr, vt[i].wdata, vt[i].size);
        end

        for (int i = 0; i < 150; i++) begin
            a  = $urandom;
            wd = $urandom;
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            s  = 1'($urandom_range(0, 1));
            n  = nb(sz);
            esp = (int'(a[1:0]) + n) > 4;
            erd = w ? 32'h0 : model_load(a, sz, s);
            chkreq($sformatf("rnd%0d", i), 0, a, wd, w, sz, s, erd, esp, 0,
                   esp ? 3 : 2, esp ? 2 : 1);
            if (w) model_store(a, wd, sz);
        end

        // Reset in the second half of a split store
        @(negedge clk);
        cur = 0;
        valid = 1; addr = 32'h22; wdata = 32'h55667788;
        wren = 1; size = 2'd2; sgn = 0;
        @(posedge clk); #1;
        valid = 0;
        @(posedge clk); #1;
        chk("abort acc2 addr", lsu_addr, 32'h24);
        chk("abort acc2 wren", 32'(lsu_wren), 32'd1);
        #2 rst = 1;
        #1;
        chk("abort wren", 32'(lsu_wren), 32'd0);
        chk("abort type", 32'(lsu_type), 32'd0);
        chk("abort ready", 32'(ready), 32'd1);
        chk("abort rsp", 32'(rsp_valid), 32'd0);
        chk("abort addr", lsu_addr, 32'h0);
        @(negedge clk);
        rst = 0;
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1;
        end
        chk("abort no rsp", 32'(seen), 32'd0);
        ref_mem[8'h22] = 8'h88;
        ref_mem[8'h23] = 8'h77;
        chkreq("post0", 0, 32'h20, 0, 0, 2'd2, 0, model_load(32'h20, 2'd2, 0),
               0, 0, 2, 1);
        chkreq("post1", 0, 32'h24, 0, 0, 2'd2, 0, model_load(32'h24, 2'd2, 0),
               0, 0, 2, 1);

        chkreq("rej0", 1, 32'h1, 0, 0, 2'd2, 0, 32'h0, 0, 1, 1, 0);
        chkreq("rej1", 1, 32'h2, 32'hFFFF, 1, 2'd2, 0, 32'h0, 0, 1, 1, 0);
        chkreq("rej2", 1, 32'h3, 0, 0, 2'd1, 1, 32'h0, 0, 1, 1, 0);
        chkreq("rej3", 1, 32'h4, 0, 0, 2'd2, 0, 32'h87654321, 0, 0, 2, 1);
        chkreq("rej4", 1, 32'h3, 0, 0, 2'd0, 1, 32'hFFFFFF87, 0, 0, 2, 1);
        chkreq("rej5", 1, 32'h1, 0, 0, 2'd1, 0, 32'h00006543, 0, 0, 2, 1);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
